// File: rtl/mac_consume_unit.sv
// mac_consume_unit
//   Downstream consumer of the read/activate controller. The controller's rd
//   strobe issues operand reads to a synchronous buffer. Its act strobe
//   multiply-accumulates the operand pairs that the buffer returns. After len
//   products have been accumulated, the unit enters DONE and holds done high.
//   done feeds back to the controller to stop rd/act. Only clr leaves DONE.
//
//   Optional feature: define MAC_SAT_EN for saturating accumulation. The
//   accumulator then clamps at the signed ACCW limits, and the sticky
//   sat_flag output is added to the port list. Without the macro, the
//   accumulator wraps modulo 2^ACCW and sat_flag does not exist.
//
// Parameters
//   DW    operand width (signed two's complement)
//   AW    read address width
//   CW    length/count width
//   ACCW  accumulator width (must be >= 2*DW)
//   BASE  first read address
//
// Ports
//   clk        clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   clr        synchronous clear, highest priority, returns to IDLE
//   rd         read strobe from controller
//   act        activate/compute strobe from controller
//   len        number of products per job
//   rd_en      buffer read enable (combinational)
//   rd_addr    buffer read address, BASE + issue count
//   op_a/op_b  operands from buffer, valid one cycle after rd_en
//   acc_out    registered final result, updated on entry to DONE
//   acc_valid  one-cycle pulse when acc_out becomes final
//   done       job complete level
//   sat_flag   sticky saturation indicator (MAC_SAT_EN only)
module mac_consume_unit #(
  parameter int DW   = 8,
  parameter int AW   = 8,
  parameter int CW   = 8,
  parameter int ACCW = 24,
  parameter int BASE = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            rd,
  input  logic            act,
  input  logic [CW-1:0]   len,
  output logic            rd_en,
  output logic [AW-1:0]   rd_addr,
  input  logic [DW-1:0]   op_a,
  input  logic [DW-1:0]   op_b,
  output logic [ACCW-1:0] acc_out,
  output logic            acc_valid,
  output logic            done
`ifdef MAC_SAT_EN
  ,
  output logic            sat_flag
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state;
  state_t                 state_next;
  logic [CW-1:0]          issue_cnt;
  logic [CW-1:0]          use_cnt;
  logic [CW-1:0]          len_q;
  logic [CW-1:0]          eff_len;
  logic [ACCW-1:0]        acc;
  logic [ACCW-1:0]        acc_next;
  logic [ACCW-1:0]        prod_ext;
  logic signed [2*DW-1:0] prod;
  logic                   acc_en;
  logic                   last_use;
  logic                   start_job;
  logic                   enter_done;
`ifdef MAC_SAT_EN
  logic [ACCW:0]          sum_wide;
  logic                   sat_hit;
`endif

  // Control decode and next state.
  // The job length is not latched until the first IDLE cycle ends, so in
  // IDLE the read limit comes straight from the len input.
  always_comb begin
    eff_len    = (state == IDLE) ? len : len_q;
    rd_en      = rd && !clr && (state != DONE) && (issue_cnt < eff_len);
    start_job  = (state == IDLE) && rd && (len != '0);
    acc_en     = (state == RUN) && act && !clr && (use_cnt < len_q);
    last_use   = acc_en && (use_cnt == (len_q - CW'(1)));
    state_next = state;
    case (state)
      IDLE:    if (rd) state_next = (len != '0) ? RUN : DONE;
      RUN:     if (last_use) state_next = DONE;
      DONE:    state_next = DONE;
      default: state_next = IDLE;
    endcase
    if (clr) state_next = IDLE;
    enter_done = (state != DONE) && (state_next == DONE);
  end

  // Signed product, sign-extended to the accumulator width.
  // The explicit casts widen each operand before the multiply, so the full
  // 2*DW product is kept.
  always_comb begin
    prod     = (2*DW)'($signed(op_a)) * (2*DW)'($signed(op_b));
    prod_ext = ACCW'(prod);
  end

`ifdef MAC_SAT_EN
  // Saturating add.
  // The sum is formed one bit wider than the accumulator. When the top two
  // bits of that sum disagree, the signed result has left the ACCW range:
  // a top bit of 0 means positive overflow, and 1 means negative overflow.
  always_comb begin
    sum_wide = {acc[ACCW-1], acc} + {prod_ext[ACCW-1], prod_ext};
    sat_hit  = (sum_wide[ACCW] != sum_wide[ACCW-1]);
    if (!sat_hit)
      acc_next = sum_wide[ACCW-1:0];
    else if (sum_wide[ACCW])
      acc_next = {1'b1, {(ACCW-1){1'b0}}};
    else
      acc_next = {1'b0, {(ACCW-1){1'b1}}};
  end
`else
  // Plain modular add; overflow simply wraps.
  always_comb begin
    acc_next = acc + prod_ext;
  end
`endif

  assign rd_addr = AW'(BASE) + AW'(issue_cnt);
  assign done    = (state == DONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Counters, accumulator and result registers.
  // When the final product arrives, acc_out captures the post-add value in
  // the same edge that enters DONE, so the result is valid together with
  // done and acc_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt <= '0;
      use_cnt   <= '0;
      len_q     <= '0;
      acc       <= '0;
      acc_out   <= '0;
      acc_valid <= 1'b0;
`ifdef MAC_SAT_EN
      sat_flag  <= 1'b0;
`endif
    end else if (clr) begin
      issue_cnt <= '0;
      use_cnt   <= '0;
      len_q     <= '0;
      acc       <= '0;
      acc_out   <= '0;
      acc_valid <= 1'b0;
`ifdef MAC_SAT_EN
      sat_flag  <= 1'b0;
`endif
    end else begin
      acc_valid <= enter_done;
      if (start_job) len_q <= len;
      if (rd_en) issue_cnt <= issue_cnt + CW'(1);
      if (acc_en) begin
        acc     <= acc_next;
        use_cnt <= use_cnt + CW'(1);
      end
      if (enter_done) acc_out <= last_use ? acc_next : acc;
`ifdef MAC_SAT_EN
      if (acc_en && sat_hit) sat_flag <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_mac_consume_unit.sv
// tb_mac_consume_unit
//   Drives two copies of mac_consume_unit with the same stimulus. One copy
//   uses the default 24-bit accumulator; the other uses a 16-bit accumulator
//   to expose overflow behaviour. A behavioural buffer returns operands one
//   cycle after rd_en. A job-level reference model predicts every output:
//   the k-th product of a job is taken from address BASE+k, and the running
//   sum is kept as a plain integer.
//   Define MAC_SAT_EN to check the saturating build.
module tb_mac_consume_unit;
  localparam int DW     = 8;
  localparam int AW     = 8;
  localparam int CW     = 8;
  localparam int ACCW   = 24;
  localparam int ACCW16 = 16;
  localparam int BASE   = 0;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clr;
  logic              rd;
  logic              act;
  logic [CW-1:0]     len;
  logic              rd_en;
  logic              rd_en16;
  logic [AW-1:0]     rd_addr;
  logic [AW-1:0]     rd_addr16;
  logic [DW-1:0]     op_a = '0;
  logic [DW-1:0]     op_b = '0;
  logic [ACCW-1:0]   acc_out;
  logic [ACCW16-1:0] acc_out16;
  logic              acc_valid;
  logic              acc_valid16;
  logic              done;
  logic              done16;
`ifdef MAC_SAT_EN
  logic              sat_flag;
  logic              sat_flag16;
`endif

  logic [DW-1:0] mem_a [256];
  logic [DW-1:0] mem_b [256];

  int checks   = 0;
  int failures = 0;

  bit     m_busy, m_done, m_valid, m_sat24, m_sat16;
  int     m_issue, m_used, m_len;
  longint m_sum24, m_sum16, m_out24, m_out16;

  mac_consume_unit #(.DW(DW), .AW(AW), .CW(CW), .ACCW(ACCW), .BASE(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .rd(rd), .act(act), .len(len),
    .rd_en(rd_en), .rd_addr(rd_addr), .op_a(op_a), .op_b(op_b),
    .acc_out(acc_out), .acc_valid(acc_valid), .done(done)
`ifdef MAC_SAT_EN
    , .sat_flag(sat_flag)
`endif
  );

  mac_consume_unit #(.DW(DW), .AW(AW), .CW(CW), .ACCW(ACCW16), .BASE(BASE)) dut16 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .rd(rd), .act(act), .len(len),
    .rd_en(rd_en16), .rd_addr(rd_addr16), .op_a(op_a), .op_b(op_b),
    .acc_out(acc_out16), .acc_valid(acc_valid16), .done(done16)
`ifdef MAC_SAT_EN
    , .sat_flag(sat_flag16)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous operand buffer: data appears one cycle after rd_en.
  always @(posedge clk) begin
    if (rd_en) begin
      op_a <= mem_a[rd_addr];
      op_b <= mem_b[rd_addr];
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  // One accumulation step on a signed integer of the given width.
  function automatic longint acc_step(input longint s, input longint p, input int w, output bit sat);
    longint range, hi, lo, r;
    range = longint'(1) << w;
    hi    = (range >> 1) - 1;
    lo    = -(range >> 1);
    r     = s + p;
    sat   = 1'b0;
`ifdef MAC_SAT_EN
    if (r > hi) begin r = hi; sat = 1'b1; end
    else if (r < lo) begin r = lo; sat = 1'b1; end
`else
    while (r > hi) r = r - range;
    while (r < lo) r = r + range;
`endif
    return r;
  endfunction

  function automatic logic [63:0] to_bits(input longint v, input int w);
    return 64'(v) & ((64'd1 << w) - 64'd1);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_busy = 0; m_done = 0; m_valid = 0; m_sat24 = 0; m_sat16 = 0;
    m_issue = 0; m_used = 0; m_len = 0;
    m_sum24 = 0; m_sum16 = 0; m_out24 = 0; m_out16 = 0;
  endtask

  // Check outputs for the current cycle, advance the model, then step one
  // clock. Called #1 after a rising edge; returns #1 after the next one.
  task automatic applyStimulus(input bit rd_v, input bit act_v, input bit clr_v, input int len_v);
    bit     exp_rd_en, s24, s16;
    int     addr;
    longint p;
    rd = rd_v; act = act_v; clr = clr_v; len = CW'(len_v);
    #1;
    exp_rd_en = !clr_v && rd_v && !m_done && (m_issue < (m_busy ? m_len : len_v));
    checkOutput("rd_en", 64'(rd_en), 64'(exp_rd_en));
    checkOutput("rd_en16", 64'(rd_en16), 64'(exp_rd_en));
    checkOutput("rd_addr", 64'(rd_addr), 64'((BASE + m_issue) % 256));
    checkOutput("done", 64'(done), 64'(m_done));
    checkOutput("done16", 64'(done16), 64'(m_done));
    checkOutput("acc_valid", 64'(acc_valid), 64'(m_valid));
    checkOutput("acc_valid16", 64'(acc_valid16), 64'(m_valid));
    checkOutput("acc_out", 64'(acc_out), to_bits(m_out24, ACCW));
    checkOutput("acc_out16", 64'(acc_out16), to_bits(m_out16, ACCW16));
`ifdef MAC_SAT_EN
    checkOutput("sat_flag", 64'(sat_flag), 64'(m_sat24));
    checkOutput("sat_flag16", 64'(sat_flag16), 64'(m_sat16));
`endif
    m_valid = 0;
    if (clr_v) begin
      modelReset();
    end else begin
      if (exp_rd_en) m_issue++;
      if (!m_busy && !m_done && rd_v) begin
        if (len_v != 0) begin
          m_busy = 1; m_len = len_v;
        end else begin
          m_done = 1; m_valid = 1; m_out24 = m_sum24; m_out16 = m_sum16;
        end
      end else if (m_busy && act_v && m_used < m_len) begin
        addr = (BASE + m_used) % 256;
        p = longint'(int'($signed(mem_a[addr]))) * longint'(int'($signed(mem_b[addr])));
        m_sum24 = acc_step(m_sum24, p, ACCW, s24);
        m_sum16 = acc_step(m_sum16, p, ACCW16, s16);
        m_sat24 = m_sat24 | s24;
        m_sat16 = m_sat16 | s16;
        m_used++;
        if (m_used == m_len) begin
          m_busy = 0; m_done = 1; m_valid = 1; m_out24 = m_sum24; m_out16 = m_sum16;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Run one job: n reads plus 'extra' surplus rd cycles, optional random
  // gaps in rd, and act following rd by one cycle. With gaps enabled, len
  // is scrambled once the job has started.
  task automatic runJob(input int n, input int extra, input bit gaps);
    int driven = 0;
    bit r;
    bit pr = 0;
    int lv;
    for (int c = 0; c < 200 && (driven < n + extra || pr); c++) begin
      r  = (driven < n + extra) && (!gaps || $urandom_range(0, 3) != 0);
      lv = ((m_busy || m_done) && gaps) ? int'($urandom_range(0, 255)) : n;
      applyStimulus(r, pr, 1'b0, lv);
      driven += int'(r);
      pr = r;
    end
    for (int w = 0; w < 4 && !done; w++) applyStimulus(1'b0, 1'b0, 1'b0, n);
    checkOutput("job_done", 64'(done), 64'd1);
  endtask

  task automatic clearJob();
    applyStimulus(1'b0, 1'b0, 1'b1, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic loadRandom(input int n);
    for (int i = 0; i < n; i++) begin
      mem_a[(BASE + i) % 256] = DW'($urandom);
      mem_b[(BASE + i) % 256] = DW'($urandom);
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0; rd = 1'b0; act = 1'b0; clr = 1'b0; len = '0;
    modelReset();
    for (int i = 0; i < 256; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
    #12;
    checkOutput("rst_rd_en", 64'(rd_en), 64'd0);
    checkOutput("rst_rd_addr", 64'(rd_addr), 64'(BASE));
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_acc_valid", 64'(acc_valid), 64'd0);
    checkOutput("rst_acc_out", 64'(acc_out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] directed len=4 job");
    mem_a[0] = 8'd1;   mem_b[0] = 8'd2;
    mem_a[1] = 8'd3;   mem_b[1] = 8'd4;
    mem_a[2] = 8'hFF;  mem_b[2] = 8'd5;
    mem_a[3] = 8'd2;   mem_b[3] = 8'd2;
    runJob(4, 0, 1'b0);
    clearJob();

    $display("[TB] len=0 job");
    runJob(0, 1, 1'b0);
    clearJob();

    $display("[TB] len=3 with surplus rd/act");
    loadRandom(3);
    runJob(3, 3, 1'b0);
    clearJob();

    $display("[TB] mid-job clear then fresh len=2 job");
    loadRandom(4);
    applyStimulus(1'b1, 1'b0, 1'b0, 4);
    applyStimulus(1'b1, 1'b1, 1'b0, 4);
    applyStimulus(1'b1, 1'b1, 1'b0, 4);
    applyStimulus(1'b1, 1'b1, 1'b1, 4);
    applyStimulus(1'b0, 1'b0, 1'b0, 4);
    loadRandom(2);
    runJob(2, 0, 1'b0);
    clearJob();

    $display("[TB] overflow job");
    for (int i = 0; i < 4; i++) begin mem_a[i] = 8'h80; mem_b[i] = 8'h80; end
    runJob(4, 0, 1'b0);
    clearJob();

    $display("[TB] asynchronous reset mid-job");
    loadRandom(4);
    applyStimulus(1'b1, 1'b0, 1'b0, 4);
    applyStimulus(1'b1, 1'b1, 1'b0, 4);
    rd = 1'b0; act = 1'b0; rst_n = 1'b0;
    #2;
    checkOutput("arst_rd_en", 64'(rd_en), 64'd0);
    checkOutput("arst_rd_addr", 64'(rd_addr), 64'(BASE));
    checkOutput("arst_done", 64'(done), 64'd0);
    checkOutput("arst_acc_valid", 64'(acc_valid), 64'd0);
    checkOutput("arst_acc_out", 64'(acc_out), 64'd0);
    checkOutput("arst_acc_out16", 64'(acc_out16), 64'd0);
    modelReset();
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] randomized jobs");
    repeat (8) begin
      n = int'($urandom_range(1, 8));
      loadRandom(n);
      runJob(n, int'($urandom_range(0, 2)), 1'b1);
      clearJob();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
